// File: rtl/clk_div_gen_if.sv
// clk_div_gen_if: control/status bundle between the CTRL registers, the divider and the clock mux.
// tick_count is carried only when CLK_DIV_TICK_CNT_EN is defined.
interface clk_div_gen_if #(parameter int DF_W = 6);
   logic            enable;
   logic [DF_W-1:0] divide_factor;
   logic            div_clk;
   logic            div_tick;
   logic [DF_W-1:0] active_factor;
   logic            update_pending;
`ifdef CLK_DIV_TICK_CNT_EN
   logic [15:0]     tick_count;
   modport master (
      output enable, divide_factor,
      input  div_clk, div_tick, active_factor, update_pending, tick_count
   );
   modport slave (
      input  enable, divide_factor,
      output div_clk, div_tick, active_factor, update_pending, tick_count
   );
`else
   modport master (
      output enable, divide_factor,
      input  div_clk, div_tick, active_factor, update_pending
   );
   modport slave (
      input  enable, divide_factor,
      output div_clk, div_tick, active_factor, update_pending
   );
`endif
endinterface

// File: rtl/clk_div_gen.sv
// clk_div_gen: runt-free programmable clock divider with per-period tick enable.
// Optional CLK_DIV_TICK_CNT_EN adds a free-running 16-bit count of div_tick pulses.
module clk_div_gen #(
   parameter int DF_W  = 6,
   parameter int CNT_W = 6
) (
   input logic          CLK,
   input logic          RESETn,
   clk_div_gen_if.slave bus
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [DF_W-1:0]   af, af_nx;
   logic              div_clk_q, div_clk_nx;
   logic              wrap;
   logic              div_tick;

   // Factors 0 and 1 cannot form a clock, so they fall back to a period of 2.
   function automatic logic [CNT_W-1:0] period_of(input logic [DF_W-1:0] n);
      return (n < DF_W'(2)) ? CNT_W'(2) : CNT_W'(n);
   endfunction

   function automatic logic [CNT_W-1:0] high_of(input logic [DF_W-1:0] n);
      logic [CNT_W:0] p1;
      p1 = {1'b0, period_of(n)} + (CNT_W+1)'(1);
      return p1[CNT_W:1];
   endfunction

   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn) begin
         state     <= IDLE;
         cnt       <= '0;
         af        <= '0;
         div_clk_q <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         af        <= af_nx;
         div_clk_q <= div_clk_nx;
      end

   // The factor is only resampled on the wrap edge, so a period always completes with its own P/H.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      af_nx      = af;
      div_clk_nx = div_clk_q;
      wrap       = cnt == period_of(af) - CNT_W'(1);
      if (!bus.enable) begin
         state_nx   = IDLE;
         cnt_nx     = '0;
         div_clk_nx = 1'b0;
      end else if (state == IDLE) begin
         state_nx   = RUN;
         cnt_nx     = '0;
         af_nx      = bus.divide_factor;
         div_clk_nx = 1'b1;
      end else begin
         cnt_nx     = wrap ? '0 : cnt + CNT_W'(1);
         af_nx      = wrap ? bus.divide_factor : af;
         div_clk_nx = cnt_nx < high_of(af_nx);
      end
   end

   assign div_tick           = (state == RUN) && (cnt == '0);
   assign bus.div_tick       = div_tick;
   assign bus.div_clk        = div_clk_q;
   assign bus.active_factor  = af;
   assign bus.update_pending = (state == RUN) && (bus.divide_factor != af);

`ifdef CLK_DIV_TICK_CNT_EN
   logic [15:0] tick_cnt;

   always_ff @(posedge CLK or negedge RESETn)
      if (!RESETn)
         tick_cnt <= '0;
      else if (!bus.enable)
         tick_cnt <= '0;
      else if (div_tick)
         tick_cnt <= tick_cnt + 16'd1;

   assign bus.tick_count = tick_cnt;
`endif
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: scoreboard bench for clk_div_gen; expected per-cycle outputs are queued
// when stimulus is applied and compared on each falling CLK edge.
module tb_clk_div_gen;
   typedef struct {
      logic       clk;
      logic       tick;
      logic [5:0] af;
      logic       up;
   } exp_t;

   logic CLK = 1'b0;
   logic RESETn;
   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;

   clk_div_gen_if #(.DF_W(6)) bus ();

   clk_div_gen #(.DF_W(6), .CNT_W(6)) dut (
      .CLK    (CLK),
      .RESETn (RESETn),
      .bus    (bus)
   );

   always #5 CLK = ~CLK;

   task automatic push_period(input int n);
      int p, h;
      p = (n < 2) ? 2 : n;
      h = (p + 1) / 2;
      for (int i = 0; i < p; i++) sb.push_back('{i < h, i == 0, 6'(n), 1'b0});
   endtask

   task automatic test_reset;
      RESETn            = 1'b0;
      bus.enable        = 1'b0;
      bus.divide_factor = 6'd9;
      #1;
      checks++;
      if ({bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending} !== 9'd0) begin
         fails++;
         $display("FAIL reset_async got %b want 0", {bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending});
      end
      repeat (2) @(negedge CLK);
      RESETn = 1'b1;
      @(negedge CLK);
      checks++;
      if ({bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending} !== 9'd0) begin
         fails++;
         $display("FAIL reset_idle got %b want 0", {bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending});
      end
   endtask

   task automatic test_n4;
      exp_t e;
      bus.divide_factor = 6'd4;
      bus.enable        = 1'b1;
      repeat (3) push_period(4);
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge CLK);
         e = sb.pop_front();
         checks++;
         if ({bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending} !== {e.clk, e.tick, e.af, e.up}) begin
            fails++;
            $display("FAIL n4[%0d] got clk=%b tick=%b af=%0d up=%b want clk=%b tick=%b af=%0d up=%b",
                     i, bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending, e.clk, e.tick, e.af, e.up);
         end
      end
   endtask

   task automatic test_change;
      exp_t e;
      bus.enable = 1'b0;
      @(negedge CLK);
      checks++;
      if ({bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending} !== {2'b00, 6'd4, 1'b0}) begin
         fails++;
         $display("FAIL change_idle got %b want %b", {bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending}, {2'b00, 6'd4, 1'b0});
      end
      bus.divide_factor = 6'd3;
      bus.enable        = 1'b1;
      repeat (2) push_period(3);
      repeat (2) push_period(5);
      sb[5].up = 1'b1;
      sb[8].up = 1'b1;
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge CLK);
         e = sb.pop_front();
         checks++;
         if ({bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending} !== {e.clk, e.tick, e.af, e.up}) begin
            fails++;
            $display("FAIL change[%0d] got clk=%b tick=%b af=%0d up=%b want clk=%b tick=%b af=%0d up=%b",
                     i, bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending, e.clk, e.tick, e.af, e.up);
         end
         if (i == 4) begin
            bus.divide_factor = 6'd5;
            #1;
            checks++;
            if (bus.update_pending !== 1'b1) begin
               fails++;
               $display("FAIL pending_immediate got %b want 1", bus.update_pending);
            end
         end
         if (i == 7) bus.divide_factor = 6'd9;
         if (i == 8) bus.divide_factor = 6'd5;
      end
   endtask

   task automatic test_small;
      exp_t e;
      logic [5:0] prev_af;
      prev_af = 6'd5;
      for (int n = 0; n < 3; n++) begin
         bus.enable = 1'b0;
         @(negedge CLK);
         checks++;
         if ({bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending} !== {2'b00, prev_af, 1'b0}) begin
            fails++;
            $display("FAIL small_idle n=%0d got %b want %b", n, {bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending}, {2'b00, prev_af, 1'b0});
         end
         bus.divide_factor = 6'(n);
         bus.enable        = 1'b1;
         repeat (3) push_period(n);
         for (int i = 0; sb.size() > 0; i++) begin
            @(negedge CLK);
            e = sb.pop_front();
            checks++;
            if ({bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending} !== {e.clk, e.tick, e.af, e.up}) begin
               fails++;
               $display("FAIL small n=%0d [%0d] got clk=%b tick=%b af=%0d want clk=%b tick=%b af=%0d",
                        n, i, bus.div_clk, bus.div_tick, bus.active_factor, e.clk, e.tick, e.af);
            end
         end
         prev_af = 6'(n);
      end
   endtask

   task automatic test_abort;
      exp_t e;
      bus.enable = 1'b0;
      @(negedge CLK);
      checks++;
      if ({bus.div_clk, bus.div_tick, bus.active_factor} !== {2'b00, 6'd2}) begin
         fails++;
         $display("FAIL abort_idle got %b want %b", {bus.div_clk, bus.div_tick, bus.active_factor}, {2'b00, 6'd2});
      end
      bus.divide_factor = 6'd7;
      bus.enable        = 1'b1;
      sb.push_back('{1'b1, 1'b1, 6'd7, 1'b0});
      sb.push_back('{1'b1, 1'b0, 6'd7, 1'b0});
      sb.push_back('{1'b1, 1'b0, 6'd7, 1'b0});
      sb.push_back('{1'b0, 1'b0, 6'd7, 1'b0});
      repeat (2) push_period(6);
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge CLK);
         e = sb.pop_front();
         checks++;
         if ({bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending} !== {e.clk, e.tick, e.af, e.up}) begin
            fails++;
            $display("FAIL abort[%0d] got clk=%b tick=%b af=%0d up=%b want clk=%b tick=%b af=%0d up=%b",
                     i, bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending, e.clk, e.tick, e.af, e.up);
         end
         if (i == 2) bus.enable = 1'b0;
         if (i == 3) begin
            bus.divide_factor = 6'd6;
            bus.enable        = 1'b1;
         end
      end
   endtask

   task automatic test_async_reset;
      exp_t e;
      bus.enable = 1'b0;
      @(negedge CLK);
      bus.divide_factor = 6'd10;
      bus.enable        = 1'b1;
      sb.push_back('{1'b1, 1'b1, 6'd10, 1'b0});
      sb.push_back('{1'b1, 1'b0, 6'd10, 1'b0});
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge CLK);
         e = sb.pop_front();
         checks++;
         if ({bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending} !== {e.clk, e.tick, e.af, e.up}) begin
            fails++;
            $display("FAIL areset_pre[%0d] got clk=%b tick=%b af=%0d want clk=%b tick=%b af=%0d",
                     i, bus.div_clk, bus.div_tick, bus.active_factor, e.clk, e.tick, e.af);
         end
      end
      #2 RESETn = 1'b0;
      #1;
      checks++;
      if ({bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending} !== 9'd0) begin
         fails++;
         $display("FAIL areset_async got %b want 0", {bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending});
      end
      #1 RESETn = 1'b1;
      repeat (2) push_period(10);
      for (int i = 0; sb.size() > 0; i++) begin
         @(negedge CLK);
         e = sb.pop_front();
         checks++;
         if ({bus.div_clk, bus.div_tick, bus.active_factor, bus.update_pending} !== {e.clk, e.tick, e.af, e.up}) begin
            fails++;
            $display("FAIL areset_post[%0d] got clk=%b tick=%b af=%0d want clk=%b tick=%b af=%0d",
                     i, bus.div_clk, bus.div_tick, bus.active_factor, e.clk, e.tick, e.af);
         end
      end
   endtask

`ifdef CLK_DIV_TICK_CNT_EN
   task automatic test_tick_count;
      logic [15:0] prev;
      int          wraps;
      bus.enable = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.tick_count !== 16'h0000) begin
         fails++;
         $display("FAIL tc_clear_start got %h want 0000", bus.tick_count);
      end
      bus.divide_factor = 6'd2;
      bus.enable        = 1'b1;
      prev  = 16'h0000;
      wraps = 0;
      for (int c = 1; c <= 131072; c++) begin
         @(negedge CLK);
         if (prev == 16'hFFFF && bus.tick_count == 16'h0000) wraps++;
         prev = bus.tick_count;
         if (c == 131070) begin
            checks++;
            if (bus.tick_count !== 16'hFFFF) begin
               fails++;
               $display("FAIL tc_full got %h want ffff", bus.tick_count);
            end
         end
      end
      checks++;
      if (bus.tick_count !== 16'h0000 || wraps != 1) begin
         fails++;
         $display("FAIL tc_wrap got %h wraps=%0d want 0000 wraps=1", bus.tick_count, wraps);
      end
      repeat (2) @(negedge CLK);
      checks++;
      if (bus.tick_count !== 16'h0001) begin
         fails++;
         $display("FAIL tc_after_wrap got %h want 0001", bus.tick_count);
      end
      bus.enable = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.tick_count !== 16'h0000) begin
         fails++;
         $display("FAIL tc_clear got %h want 0000", bus.tick_count);
      end
   endtask
`endif

   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_n4();
      test_change();
      test_small();
      test_abort();
      test_async_reset();
`ifdef CLK_DIV_TICK_CNT_EN
      test_tick_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Consumes the divide_factor control field from the APB register block and generates a divided clock plus a one-cycle tick enable for the GCD datapath clock domain.
- Factor changes are applied only at a period boundary, so div_clk never produces a runt pulse.
- Sits between the APB control registers and the clock mux driven by mux_select.

Parameters:
DF_W, 6, width of divide_factor / active_factor
CNT_W, 6, width of internal period counter; must be >= DF_W

Ports:
CLK  input  1  system clock
RESETn  input  1  reset, asynchronous, active-low
enable  input  1  run request; low holds divider idle
divide_factor  input  DF_W  requested factor N from CTRL register
div_clk  output  1  divided clock, driven directly from a flop
div_tick  output  1  one-CLK pulse at the start of each div_clk period
active_factor  output  DF_W  factor currently in effect, raw N
update_pending  output  1  divide_factor differs from active_factor while running

Behaviour:
- Reset (async, RESETn=0): running=0, cnt=0, active_factor=0, div_clk=0, div_tick=0, update_pending=0.
- Effective period P = (N<2) ? 2 : N CLK cycles. High time H = ceil(P/2); low time = P-H. Example duty patterns:
  - N=0/1/2: 1,0
  - N=3: 1,1,0
  - N=4: 1,1,0,0
  - N=63: 32 high, 31 low
- IDLE (running=0): on an edge with enable=1:
  - running<=1, cnt<=0, active_factor<=divide_factor, div_clk<=1.
  - Result: first high phase begins 1 cycle after enable is sampled high.
- RUN (running=1), each edge with enable=1:
  - cnt<=(cnt==P-1)?0:cnt+1.
  - When cnt wraps, active_factor<=divide_factor (new P/H take effect for the period starting then).
  - div_clk<=(next_cnt < H of the period that next_cnt belongs to).
- div_tick=1 exactly in cycles where running=1 and cnt==0, including the first period. Derived from registers only; no combinational path from inputs.
- divide_factor changes mid-period: the current period completes with the old P/H; the new value is sampled only on the wrap edge. Intermediate values changed and restored before the wrap are ignored.
- update_pending=running && (divide_factor != active_factor). Combinational from divide_factor; consumers must treat it as a status flag only.
- enable deasserted (any cnt): next edge forces running<=0, cnt<=0, div_clk<=0, div_tick<=0. The period is aborted immediately and active_factor is retained.
- enable re-asserted after that: restarts from IDLE rules with a fresh factor sample.
- Reset mid-operation: all state returns to reset values asynchronously. Operation restarts only via an IDLE->RUN transition after RESETn is released.
- Counter never exceeds P-1 (max 62 for DF_W=6); no overflow path.

Optional Feature:
CLK_DIV_TICK_CNT_EN
- Defined:
  - Adds output tick_count[15:0].
  - Increments by 1 on every cycle div_tick=1 and wraps 0xFFFF->0x0000.
  - Cleared to 0 by reset and on the edge where enable is sampled low.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, enable=1, N=4 held -> div_clk 1,1,0,0 repeating starting 1 cycle after enable; div_tick high every 4th cycle with div_clk's rise; active_factor=4.
- Running N=3, change divide_factor to 5 when cnt=1 -> update_pending=1 until the wrap; pattern 1,1,0 completes, then 1,1,1,0,0; active_factor=5 from the wrap.
- N=0, then N=1, then N=2 -> div_clk toggles every cycle (1,0) in all three cases; div_tick every 2 cycles.
- Running N=7, drop enable at cnt=2 -> next cycle div_clk=0, div_tick=0; re-enable with N=6 -> 1,1,1,0,0,0 pattern begins 1 cycle later.
- Assert RESETn=0 asynchronously mid-high-phase with N=10 -> div_clk, div_tick and active_factor go to 0 without waiting for a CLK edge; after release, enable=1 restarts cleanly.
- With CLK_DIV_TICK_CNT_EN, N=2 for 131072 cycles -> tick_count wraps 0xFFFF->0x0000 exactly once and reads 0x0000 at the end; enable low clears it to 0.
